// File: rtl/rtype_sequencer.sv
// rtype_sequencer: multi-cycle control FSM for the R-type path (decode -> exec -> write-back).
// Optional retire/illegal counters are built when `RTYPE_SEQ_PERF_EN is defined.
module rtype_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Flush,
  input  logic        InstValid,
  output logic        InstReady,
  input  logic [31:0] Inst,
  output logic [4:0]  RegRs,
  output logic [4:0]  RegRt,
  output logic [4:0]  RegRd,
  output logic        RegRdEn,
  output logic [2:0]  Aop,
  output logic [5:0]  Func,
  output logic        AluLatch,
  output logic        RegWe,
  output logic        Done,
  output logic        Illegal,
  output logic        Busy
`ifdef RTYPE_SEQ_PERF_EN
  ,
  output logic [31:0] RetireCount,
  output logic [15:0] IllegalCount
`endif
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StWb     = 3'd3,
    StIll    = 3'd4
  } state_e;

  localparam logic [3:0] CntLast = 4'(EXEC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        legal;
  logic        funct_ok;
  logic        unused_shamt;

  assign unused_shamt = ^inst_q[10:6];

  always_comb begin
    funct_ok = 1'b0;
    case (inst_q[5:0])
      6'b100000, 6'b100010, 6'b100100,
      6'b101010, 6'b100101, 6'b100011: funct_ok = 1'b1;
      default:                         funct_ok = 1'b0;
    endcase
  end

  assign legal = (inst_q[31:26] == 6'd0) && funct_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    if (Flush) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (InstValid) begin
            inst_d  = Inst;
            state_d = StDecode;
          end
        end
        StDecode: begin
          cnt_d   = 4'd0;
          state_d = legal ? StExec : StIll;
        end
        StExec: begin
          if (cnt_q == CntLast) begin
            cnt_d   = 4'd0;
            state_d = StWb;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StWb:    state_d = StIdle;
        StIll:   state_d = StIdle;
        // Unused encodings fall back to idle.
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    InstReady = 1'b0;
    RegRdEn   = 1'b0;
    Aop       = 3'b000;
    Func      = 6'b000000;
    AluLatch  = 1'b0;
    RegWe     = 1'b0;
    Done      = 1'b0;
    Illegal   = 1'b0;
    Busy      = (state_q != StIdle);
    case (state_q)
      StIdle:   InstReady = !Flush && !reset;
      StDecode: RegRdEn   = legal && !Flush;
      StExec: begin
        Aop      = 3'b001;
        Func     = inst_q[5:0];
        AluLatch = (cnt_q == CntLast) && !Flush;
      end
      StWb: begin
        Done  = !Flush;
        RegWe = (inst_q[15:11] != 5'd0) && !Flush;
      end
      StIll:   Illegal = !Flush;
      default: ;
    endcase
  end

  assign RegRs = inst_q[25:21];
  assign RegRt = inst_q[20:16];
  assign RegRd = inst_q[15:11];

`ifdef RTYPE_SEQ_PERF_EN
  logic [31:0] retire_q;
  logic [15:0] illegal_q;

  // Counters survive Flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q  <= 32'd0;
      illegal_q <= 16'd0;
    end else begin
      if (Done) retire_q <= retire_q + 32'd1;
      if (Illegal && (illegal_q != 16'hFFFF)) illegal_q <= illegal_q + 16'd1;
    end
  end

  assign RetireCount  = retire_q;
  assign IllegalCount = illegal_q;
`endif

endmodule

// File: tb/tb_rtype_sequencer.sv
// Bench for rtype_sequencer: two instances (EXEC_CYCLES 1 and 4) on shared stimulus,
// per-cycle scoreboard of expected output vectors for the selected instance.
module tb_rtype_sequencer;

  typedef struct packed {
    logic       ready;
    logic       rden;
    logic [2:0] aop;
    logic [5:0] func;
    logic       latch;
    logic       we;
    logic       done;
    logic       ill;
    logic       busy;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, Flush, InstValid;
  logic [31:0] Inst;

  logic       rdy1, rden1, latch1, we1, done1, ill1, busy1;
  logic [2:0] aop1;
  logic [5:0] func1;
  logic [4:0] rs1, rt1, rd1;
  logic       rdy4, rden4, latch4, we4, done4, ill4, busy4;
  logic [2:0] aop4;
  logic [5:0] func4;
  logic [4:0] rs4, rt4, rd4;
`ifdef RTYPE_SEQ_PERF_EN
  logic [31:0] rc1, rc4;
  logic [15:0] ic1, ic4;
`endif

  obs_t o1, o4, obs;
  logic sel4;

  always #5 clk = ~clk;

  rtype_sequencer #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .Flush(Flush), .InstValid(InstValid), .InstReady(rdy1),
    .Inst(Inst), .RegRs(rs1), .RegRt(rt1), .RegRd(rd1), .RegRdEn(rden1), .Aop(aop1),
    .Func(func1), .AluLatch(latch1), .RegWe(we1), .Done(done1), .Illegal(ill1),
    .Busy(busy1)
`ifdef RTYPE_SEQ_PERF_EN
    , .RetireCount(rc1), .IllegalCount(ic1)
`endif
  );

  rtype_sequencer #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .Flush(Flush), .InstValid(InstValid), .InstReady(rdy4),
    .Inst(Inst), .RegRs(rs4), .RegRt(rt4), .RegRd(rd4), .RegRdEn(rden4), .Aop(aop4),
    .Func(func4), .AluLatch(latch4), .RegWe(we4), .Done(done4), .Illegal(ill4),
    .Busy(busy4)
`ifdef RTYPE_SEQ_PERF_EN
    , .RetireCount(rc4), .IllegalCount(ic4)
`endif
  );

  assign o1  = {rdy1, rden1, aop1, func1, latch1, we1, done1, ill1, busy1, rs1, rt1, rd1};
  assign o4  = {rdy4, rden4, aop4, func4, latch4, we4, done4, ill4, busy4, rs4, rt4, rd4};
  assign obs = sel4 ? o4 : o1;

  obs_t        exp_q[$];
  logic [31:0] cap_inst;
  int          n_cmp, n_bad, cyc, n_exec, exp_retire, exp_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] w);
    if (w[31:26] != 6'd0) return 1'b0;
    case (w[5:0])
      6'h20, 6'h22, 6'h24, 6'h2a, 6'h25, 6'h23: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t idle_v(input logic f);
    obs_t v;
    v       = '0;
    v.ready = !f;
    v.rs    = cap_inst[25:21];
    v.rt    = cap_inst[20:16];
    v.rd    = cap_inst[15:11];
    return v;
  endfunction

  // Expected vectors for decode, exec and wb/ill of one accepted word.
  task automatic push_inst(input logic [31:0] w);
    obs_t v;
    cap_inst = w;
    v        = '0;
    v.busy   = 1'b1;
    v.rs     = w[25:21];
    v.rt     = w[20:16];
    v.rd     = w[15:11];
    v.rden   = is_legal(w);
    exp_q.push_back(v);
    v.rden = 1'b0;
    if (is_legal(w)) begin
      for (int i = 0; i < n_exec; i++) begin
        v.aop   = 3'b001;
        v.func  = w[5:0];
        v.latch = (i == n_exec - 1);
        exp_q.push_back(v);
      end
      v.aop   = 3'b000;
      v.func  = 6'd0;
      v.latch = 1'b0;
      v.we    = (w[15:11] != 5'd0);
      v.done  = 1'b1;
      exp_q.push_back(v);
    end else begin
      v.ill = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] w, input logic f, input string tag);
    obs_t want;
    logic idle;
    InstValid = v;
    Inst      = w;
    Flush     = f;
    #1;
    idle = (exp_q.size() == 0);
    want = idle ? idle_v(f) : exp_q.pop_front();
    if (f) begin
      want.ready = 1'b0;
      want.rden  = 1'b0;
      want.latch = 1'b0;
      want.we    = 1'b0;
      want.done  = 1'b0;
      want.ill   = 1'b0;
    end
    check($sformatf("%s c%0d", tag, cyc), {1'b0, obs}, {1'b0, want});
    if (want.done) exp_retire++;
    if (want.ill) exp_ill++;
    if (f) exp_q.delete();
    else if (idle && v) push_inst(w);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    InstValid = 1'b0;
    Flush     = 1'b0;
    Inst      = 32'd0;
    @(posedge clk);
    #1;
    cap_inst = 32'd0;
    exp_q.delete();
    exp_retire = 0;
    exp_ill    = 0;
    cyc        = 0;
    check(tag, {1'b0, obs}, 32'd0);
    reset = 1'b0;
  endtask

  logic [31:0] stream [3];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel4   = 1'b0;
    n_exec = 1;
    do_reset("reset_e1");

    tick(1'b1, 32'h014B4820, 1'b0, "add");
    for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 1'b0, "add");
    tick(1'b1, 32'h8D280004, 1'b0, "lw");
    for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b0, "lw");
    tick(1'b1, 32'h00000000, 1'b0, "sll");
    for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b0, "sll");
    tick(1'b1, 32'h014B0022, 1'b0, "sub_rd0");
    for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 1'b0, "sub_rd0");

    tick(1'b1, 32'h0022182A, 1'b0, "flush_exec");
    tick(1'b0, 32'd0, 1'b0, "flush_exec");
    tick(1'b0, 32'd0, 1'b1, "flush_exec");
    tick(1'b0, 32'd0, 1'b0, "flush_exec");
    tick(1'b0, 32'd0, 1'b0, "flush_exec");

    tick(1'b1, 32'h01098824, 1'b1, "flush_idle");
    tick(1'b0, 32'd0, 1'b0, "flush_idle");
    tick(1'b0, 32'd0, 1'b0, "flush_idle");
`ifdef RTYPE_SEQ_PERF_EN
    check("retire_e1", rc1, 32'(exp_retire));
    check("illegal_e1", {16'd0, ic1}, 32'(exp_ill));
`endif

    sel4   = 1'b1;
    n_exec = 4;
    do_reset("reset_e4");
    stream[0] = 32'h014B4820;
    stream[1] = 32'h01098824;
    stream[2] = 32'h0022182A;
    for (int i = 0; i < 21; i++) tick(1'b1, stream[i / 7], 1'b0, "stream");
    tick(1'b0, 32'd0, 1'b0, "stream");
`ifdef RTYPE_SEQ_PERF_EN
    check("retire_e4", rc4, 32'(exp_retire));
    check("illegal_e4", {16'd0, ic4}, 32'(exp_ill));
`endif

    tick(1'b1, 32'h014B4820, 1'b0, "rst_mid");
    tick(1'b0, 32'd0, 1'b0, "rst_mid");
    tick(1'b0, 32'd0, 1'b0, "rst_mid");
    do_reset("rst_mid_zero");
`ifdef RTYPE_SEQ_PERF_EN
    check("retire_rst", rc4, 32'd0);
    check("illegal_rst", {16'd0, ic4}, 32'd0);
`endif
    tick(1'b0, 32'd0, 1'b0, "post_rst");
    tick(1'b0, 32'd0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
